ha_array_accumulator: RTL and testbench

- Consumer for the four half-adder partial-product rows produced by the approximate unsigned 8x8 multiplier front end.
- Captures one set of rows through a valid/ready handshake and adds them, one row per cycle, into a 16-bit product.
- Returns the product through a valid/ready output with a pass-through tag.
- Sits between the ha_array generator and the product consumer; exactness of the result is whatever the rows encode.

---
 rtl/ha_array_pkg.sv | 33 +++
 rtl/ha_row_weight.sv | 19 +
 rtl/ha_array_accumulator.sv | 113 +++++++++++
 tb/tb_ha_array_accumulator.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ha_array_pkg.sv
// Shared types, constants and row arithmetic for the ha_array partial-product accumulator.
package ha_array_pkg;

    localparam int NUM_ROWS  = 4;   // partial-product rows per operation
    localparam int ROW_SHIFT = 2;   // weight step between consecutive rows
    localparam int T_W       = 9;   // width of a row's t vector
    localparam int B_W       = 7;   // width of a row's b vector
    localparam int OUT_W     = 16;  // product width
    localparam int TAG_W     = 4;   // user tag width

    localparam int RV_W  = 10;                 // unshifted row value width
    localparam int CNT_W = $clog2(NUM_ROWS);   // row counter width
    localparam int SH_W  = $clog2(OUT_W);      // shift amount width

    // One partial-product row: t bits weigh i, b bits weigh j+2.
    typedef struct packed {
        logic [T_W-1:0] t;
        logic [B_W-1:0] b;
    } row_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Unshifted value of a row; 511 + 508 fits in RV_W bits, so no carry is lost.
    function automatic logic [RV_W-1:0] row_value(input logic [T_W-1:0] t,
                                                  input logic [B_W-1:0] b);
        return RV_W'(t) + (RV_W'(b) << 2);
    endfunction

endpackage

// File: rtl/ha_row_weight.sv
// Combinational weighting of one partial-product row into its product-width contribution.
module ha_row_weight
    import ha_array_pkg::*;
(
    input  logic [T_W-1:0]   i_t,
    input  logic [B_W-1:0]   i_b,
    input  logic [CNT_W-1:0] i_k,
    output logic [OUT_W-1:0] o_contrib
);

    logic [RV_W-1:0] w_row_val;
    logic [SH_W-1:0] w_shamt;

    assign w_row_val = row_value(i_t, i_b);
    assign w_shamt   = SH_W'(i_k) * SH_W'(ROW_SHIFT);
    // Bits shifted past OUT_W are dropped: the product is defined modulo 2^OUT_W.
    assign o_contrib = OUT_W'(w_row_val) << w_shamt;

endmodule

// File: rtl/ha_array_accumulator.sv
// Captures a set of ha_array rows, sums them one row per cycle, and hands the
// product downstream through a valid/ready port with the operation's tag.
module ha_array_accumulator
    import ha_array_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [T_W-1:0]   ha_array_0_t,
    input  logic [T_W-1:0]   ha_array_1_t,
    input  logic [T_W-1:0]   ha_array_2_t,
    input  logic [T_W-1:0]   ha_array_3_t,
    input  logic [B_W-1:0]   ha_array_0_b,
    input  logic [B_W-1:0]   ha_array_1_b,
    input  logic [B_W-1:0]   ha_array_2_b,
    input  logic [B_W-1:0]   ha_array_3_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_product,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    state_t             r_state;
    state_t             w_state_nxt;
    row_t               r_rows [NUM_ROWS];
    row_t               w_in_rows [NUM_ROWS];
    logic [CNT_W-1:0]   r_cnt;
    logic [OUT_W-1:0]   r_acc;
    logic [TAG_W-1:0]   r_tag;
    logic [OUT_W-1:0]   w_contrib;
    logic               w_accept;
    logic               w_last_row;

    assign w_in_rows[0] = '{t: ha_array_0_t, b: ha_array_0_b};
    assign w_in_rows[1] = '{t: ha_array_1_t, b: ha_array_1_b};
    assign w_in_rows[2] = '{t: ha_array_2_t, b: ha_array_2_b};
    assign w_in_rows[3] = '{t: ha_array_3_t, b: ha_array_3_b};

    assign w_accept   = in_valid && (r_state == IDLE);
    assign w_last_row = (r_cnt == CNT_W'(NUM_ROWS - 1));

    // Contribution of the row selected by the counter.
    ha_row_weight u_row_weight (
        .i_t       (r_rows[r_cnt].t),
        .i_b       (r_rows[r_cnt].b),
        .i_k       (r_cnt),
        .o_contrib (w_contrib)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, one add per cycle in ACC, hold in DONE until taken.
    always_comb begin
        // NOTE: default first so no path through the case leaves w_state_nxt unassigned (no latch).
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)   w_state_nxt = ACC;
            ACC:     if (w_last_row) w_state_nxt = DONE;
            DONE:    if (out_ready)  w_state_nxt = IDLE;
            default:                 w_state_nxt = IDLE;
        endcase
    end

    // Datapath: capture rows and tag on accept, then accumulate one row per ACC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_tag <= '0;
            // NOTE: the row holding array is tiny, so it is reset too; nothing reads it outside ACC anyway.
            for (int k = 0; k < NUM_ROWS; k++) begin
                r_rows[k] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        for (int k = 0; k < NUM_ROWS; k++) begin
                            r_rows[k] <= w_in_rows[k];
                        end
                        r_tag <= in_tag;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                ACC: begin
                    r_acc <= r_acc + w_contrib;
                    r_cnt <= r_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign out_valid   = (r_state == DONE);
    assign out_product = r_acc;
    assign out_tag     = r_tag;

endmodule

// File: tb/tb_ha_array_accumulator.sv
// Directed bench for ha_array_accumulator with a transaction-level reference model.
module tb_ha_array_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_tag = '0;
    logic [8:0]  t_in [4];
    logic [6:0]  b_in [4];
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_product;
    logic [3:0]  out_tag;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Reference model state: an operation is either absent, counting its row adds, or presenting.
    bit m_active = 1'b0;
    int m_left   = 0;
    int m_prod   = 0;
    int m_tag    = 0;

    ha_array_accumulator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_tag       (in_tag),
        .ha_array_0_t (t_in[0]),
        .ha_array_1_t (t_in[1]),
        .ha_array_2_t (t_in[2]),
        .ha_array_3_t (t_in[3]),
        .ha_array_0_b (b_in[0]),
        .ha_array_1_b (b_in[1]),
        .ha_array_2_b (b_in[2]),
        .ha_array_3_b (b_in[3]),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_product  (out_product),
        .out_tag      (out_tag),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Product straight from bit weights: sum of (t + 4*b) * 4^k, modulo 2^16.
    function automatic int model_product();
        int s = 0;
        for (int k = 0; k < 4; k++) begin
            s += (int'(t_in[k]) + 4 * int'(b_in[k])) * (1 << (2 * k));
        end
        return s % 65536;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_left   = 0;
        end else if (!m_active) begin
            if (in_valid) begin
                m_active = 1'b1;
                m_left   = 4;
                m_prod   = model_product();
                m_tag    = int'(in_tag);
            end
        end else if (m_left > 0) begin
            m_left--;
        end else if (out_ready) begin
            m_active = 1'b0;
        end
    end

    // Every cycle: handshake/status outputs always, product and tag while valid.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_in_ready", 32'(in_ready), 32'(!m_active));
            check("cmp_busy", 32'(busy), 32'(m_active));
            check("cmp_out_valid", 32'(out_valid), 32'(m_active && m_left == 0));
            if (m_active && m_left == 0) begin
                check("cmp_out_product", 32'(out_product), 32'(m_prod));
                check("cmp_out_tag", 32'(out_tag), 32'(m_tag));
            end
        end
    end

    task automatic set_rows(input logic [8:0] t0, input logic [8:0] t1, input logic [8:0] t2,
                            input logic [8:0] t3, input logic [6:0] b0, input logic [6:0] b1,
                            input logic [6:0] b2, input logic [6:0] b3, input logic [3:0] tag);
        @(negedge clk);
        #2;
        t_in[0] = t0; t_in[1] = t1; t_in[2] = t2; t_in[3] = t3;
        b_in[0] = b0; b_in[1] = b1; b_in[2] = b2; b_in[3] = b3;
        in_tag  = tag;
    endtask

    // Raise in_valid and wait (bounded) for the accept edge; returns #1 after it.
    task automatic accept(input string name, input bit keep_valid);
        int budget = 0;
        in_valid = 1'b1;
        while (!in_ready && budget < 40) begin
            @(negedge clk);
            #2;
            budget++;
        end
        check({name, "_accept_timeout"}, 32'(budget < 40), 32'd1);
        @(posedge clk);
        #1;
        if (!keep_valid) in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid rises (bounded).
    task automatic wait_valid(input string name, output int edges);
        edges = 0;
        while (!out_valid && edges < 30) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({name, "_valid_seen"}, 32'(out_valid), 32'd1);
    endtask

    task automatic release_out(input string name);
        @(negedge clk);
        #2;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run_op(input string name, input logic [15:0] exp_prod,
                          input logic [3:0] exp_tag, input bit early_ready);
        int edges;
        out_ready = early_ready;
        accept(name, 1'b0);
        wait_valid(name, edges);
        check({name, "_product"}, 32'(out_product), 32'(exp_prod));
        check({name, "_tag"}, 32'(out_tag), 32'(exp_tag));
        if (early_ready) begin
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
        end else begin
            release_out(name);
        end
    endtask

    initial begin
        int edges;
        for (int k = 0; k < 4; k++) begin
            t_in[k] = '0;
            b_in[k] = '0;
        end
        #1 rst_n = 1'b0;
        #20;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_product", 32'(out_product), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;

        // All rows zero: product 0, tag 3, out_valid four edges after the accept edge
        // (the fifth edge counting the accept edge itself).
        set_rows(9'd0, 9'd0, 9'd0, 9'd0, 7'd0, 7'd0, 7'd0, 7'd0, 4'd3);
        accept("zero", 1'b0);
        wait_valid("zero", edges);
        check("zero_latency", 32'(edges), 32'd4);
        check("zero_product", 32'(out_product), 32'd0);
        check("zero_tag", 32'(out_tag), 32'd3);
        release_out("zero");

        // Single lowest bit; out_ready already high while idle has no effect.
        set_rows(9'd1, 9'd0, 9'd0, 9'd0, 7'd0, 7'd0, 7'd0, 7'd0, 4'd1);
        run_op("t0bit0", 16'd1, 4'd1, 1'b1);

        // Row 3 b[6]: weight 8 + 6 = 14.
        set_rows(9'd0, 9'd0, 9'd0, 9'd0, 7'd0, 7'd0, 7'd0, 7'h40, 4'd2);
        run_op("b3bit6", 16'd16384, 4'd2, 1'b0);

        // Every bit set: 1019 * 85 = 86615 wraps to 21079.
        set_rows(9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'hF);
        run_op("all_ones", 16'd21079, 4'hF, 1'b0);

        // Mixed rows: 9 + 11*4 + 12*16 + 1*64 = 309.
        set_rows(9'd5, 9'd3, 9'd0, 9'd1, 7'd1, 7'd2, 7'd3, 7'd0, 4'd9);
        run_op("mixed", 16'd309, 4'd9, 1'b0);

        // Hold DONE for 10 cycles; a new in_valid during the hold must be ignored.
        set_rows(9'd7, 9'd0, 9'd0, 9'd0, 7'd0, 7'd0, 7'd0, 7'd0, 4'd12);
        accept("hold", 1'b0);
        wait_valid("hold", edges);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_product", 32'(out_product), 32'd7);
            check("hold_tag", 32'(out_tag), 32'd12);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            #2;
            if (i == 2) begin
                t_in[0] = 9'h1FF;
                in_tag  = 4'd13;
                in_valid = 1'b1;
            end
            if (i == 8) in_valid = 1'b0;
        end
        release_out("hold");

        // Back-to-back: second operation's data presented right after the first accept
        // and held valid; it is taken on the first cycle back in IDLE.
        set_rows(9'd0, 9'h100, 9'd0, 9'd0, 7'd0, 7'd0, 7'd0, 7'd0, 4'd5);
        out_ready = 1'b1;
        accept("b2b_a", 1'b1);
        t_in[1] = 9'd0;
        b_in[2] = 7'd1;
        in_tag  = 4'd6;
        wait_valid("b2b_a", edges);
        check("b2b_a_product", 32'(out_product), 32'd1024);
        check("b2b_a_tag", 32'(out_tag), 32'd5);
        @(posedge clk);
        #1;
        check("b2b_idle_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b_b_taken", 32'(busy), 32'd1);
        wait_valid("b2b_b", edges);
        check("b2b_b_latency", 32'(edges), 32'd4);
        check("b2b_b_product", 32'(out_product), 32'd64);
        check("b2b_b_tag", 32'(out_tag), 32'd6);
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset two adds into ACC: operation discarded, outputs back to reset values at once.
        set_rows(9'd5, 9'd3, 9'd0, 9'd1, 7'd1, 7'd2, 7'd3, 7'd0, 4'd10);
        accept("rst_mid", 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_product", 32'(out_product), 32'd0);
        check("rst_mid_tag", 32'(out_tag), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rst_mid_no_output", 32'(out_valid), 32'd0);
        end

        // Next operation after the aborted one computes correctly.
        set_rows(9'd2, 9'd0, 9'd1, 9'd0, 7'd0, 7'd1, 7'd0, 7'd0, 4'd4);
        run_op("after_rst", 16'd34, 4'd4, 1'b0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
